gpio_debounce: RTL and testbench

GPIO_DEBOUNCE -- requirements
Module: gpio_debounce

---
 rtl/gpio_debounce.sv | 125 ++++++++++++
 tb/tb_gpio_debounce.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/gpio_debounce.sv
// APB-programmable per-pin debounce filter: 2-flop sync, then an 8-bit stable-count per pin on a shared prescaled tick.
// Filtered level follows pad by 2 cycles in bypass, 1+max(THRESH,1) ticks when enabled; APB never stalls (PREADY=1).
module gpio_debounce #(
    parameter int APB_ADDR_WIDTH = 12
) (
    input  logic                      HCLK,
    input  logic                      HRESET,
    input  logic [APB_ADDR_WIDTH-1:0] PADDR,
    input  logic [31:0]               PWDATA,
    input  logic                      PWRITE,
    input  logic                      PSEL,
    input  logic                      PENABLE,
    output logic [31:0]               PRDATA,
    output logic                      PREADY,
    output logic                      PSLVERR,
    input  logic [31:0]               pad_in,
    output logic [31:0]               gpio_filt
);

    logic [31:0] sync_q;
    logic [31:0] s;
    logic [31:0] en;
    logic [7:0]  thresh;
    logic [15:0] prescale;
    logic [15:0] prescaler;
    logic [31:0] changed;
    logic [7:0]  cnt [32];

    logic [1:0]  addr;
    logic        wr;
    logic        rd_clr;
    logic        tick;
    logic [7:0]  thresh_eff;
    logic [31:0] filt_nxt;
    logic [7:0]  cnt_nxt [32];
    logic [15:0] prescaler_nxt;
    logic [31:0] changed_nxt;
    logic        unused_bits;

    assign addr        = PADDR[3:2];
    assign wr          = PSEL & PENABLE & PWRITE;
    assign rd_clr      = PSEL & PENABLE & ~PWRITE & (addr == 2'd3);
    assign tick        = (prescaler == prescale);
    assign thresh_eff  = (thresh == 8'd0) ? 8'd1 : thresh;
    assign PREADY      = 1'b1;
    assign PSLVERR     = 1'b0;
    assign unused_bits = ^{PADDR, PWDATA};

    always_comb begin
        PRDATA = 32'd0;
        case (addr)
            2'd0:    PRDATA = en;
            2'd1:    PRDATA = {24'd0, thresh};
            2'd2:    PRDATA = {16'd0, prescale};
            default: PRDATA = changed;
        endcase
    end

    // Counters only advance on ticks; >= lets a lowered THRESH release a pin already past it.
    always_comb begin
        filt_nxt = gpio_filt;
        for (int i = 0; i < 32; i++) begin
            cnt_nxt[i] = cnt[i];
            if (!en[i]) begin
                filt_nxt[i] = s[i];
                cnt_nxt[i]  = 8'd0;
            end else if (s[i] == gpio_filt[i]) begin
                cnt_nxt[i] = 8'd0;
            end else if (tick) begin
                if (({1'b0, cnt[i]} + 9'd1) >= {1'b0, thresh_eff}) begin
                    filt_nxt[i] = s[i];
                    cnt_nxt[i]  = 8'd0;
                end else begin
                    cnt_nxt[i] = cnt[i] + 8'd1;
                end
            end
        end
    end

    always_comb begin
        prescaler_nxt = prescaler + 16'd1;
        if (wr && (addr == 2'd2)) begin
            prescaler_nxt = 16'd0;
        end else if (tick) begin
            prescaler_nxt = 16'd0;
        end
    end

    // A pin changing during the clearing read stays set.
    assign changed_nxt = (rd_clr ? 32'd0 : changed) | (filt_nxt ^ gpio_filt);

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            sync_q    <= 32'd0;
            s         <= 32'd0;
            en        <= 32'd0;
            thresh    <= 8'h10;
            prescale  <= 16'd0;
            prescaler <= 16'd0;
            changed   <= 32'd0;
            gpio_filt <= 32'd0;
            for (int i = 0; i < 32; i++) begin
                cnt[i] <= 8'd0;
            end
        end else begin
            sync_q    <= pad_in;
            s         <= sync_q;
            prescaler <= prescaler_nxt;
            changed   <= changed_nxt;
            gpio_filt <= filt_nxt;
            for (int i = 0; i < 32; i++) begin
                cnt[i] <= cnt_nxt[i];
            end
            if (wr) begin
                case (addr)
                    2'd0:    en       <= PWDATA;
                    2'd1:    thresh   <= PWDATA[7:0];
                    2'd2:    prescale <= PWDATA[15:0];
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_gpio_debounce.sv
// Directed plus randomized bench for gpio_debounce against a rule-level reference model.
module tb_gpio_debounce;

    logic        HCLK = 1'b0;
    logic        HRESET;
    logic [11:0] PADDR;
    logic [31:0] PWDATA;
    logic        PWRITE, PSEL, PENABLE;
    logic [31:0] PRDATA;
    logic        PREADY, PSLVERR;
    logic [31:0] pad_in;
    logic [31:0] gpio_filt;

    int n_cmp = 0;
    int n_bad = 0;
    bit chk_en = 1'b0;

    // reference model state
    logic [31:0] m_s1, m_s, m_filt, m_en, m_changed;
    logic [7:0]  m_thresh;
    logic [15:0] m_pre, m_psc;
    int          m_cnt [32];

    gpio_debounce #(.APB_ADDR_WIDTH(12)) dut (
        .HCLK(HCLK), .HRESET(HRESET), .PADDR(PADDR), .PWDATA(PWDATA),
        .PWRITE(PWRITE), .PSEL(PSEL), .PENABLE(PENABLE), .PRDATA(PRDATA),
        .PREADY(PREADY), .PSLVERR(PSLVERR), .pad_in(pad_in), .gpio_filt(gpio_filt)
    );

    always #5 HCLK = ~HCLK;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] m_read(input logic [1:0] a);
        case (a)
            2'd0:    return m_en;
            2'd1:    return {24'd0, m_thresh};
            2'd2:    return {16'd0, m_pre};
            default: return m_changed;
        endcase
    endfunction

    // Applies the filter rules to the inputs present at the coming edge.
    task automatic model_step();
        logic [31:0] nf;
        int          nc [32];
        logic        tick, wr, rc;
        logic [1:0]  a;
        int          th;
        if (HRESET) begin
            m_s1 = 0; m_s = 0; m_filt = 0; m_en = 0; m_changed = 0;
            m_thresh = 8'h10; m_pre = 0; m_psc = 0;
            foreach (m_cnt[i]) m_cnt[i] = 0;
            return;
        end
        a    = PADDR[3:2];
        wr   = PSEL && PENABLE && PWRITE;
        rc   = PSEL && PENABLE && !PWRITE && (a == 2'd3);
        tick = (m_psc == m_pre);
        th   = (m_thresh == 0) ? 1 : int'(m_thresh);
        for (int i = 0; i < 32; i++) begin
            nf[i] = m_filt[i];
            nc[i] = m_cnt[i];
            if (!m_en[i]) begin
                nf[i] = m_s[i];
                nc[i] = 0;
            end else if (m_s[i] == m_filt[i]) begin
                nc[i] = 0;
            end else if (tick) begin
                if (m_cnt[i] + 1 >= th) begin
                    nf[i] = m_s[i];
                    nc[i] = 0;
                end else begin
                    nc[i] = m_cnt[i] + 1;
                end
            end
        end
        m_changed = (rc ? 32'd0 : m_changed) | (nf ^ m_filt);
        if ((wr && a == 2'd2) || tick) m_psc = 0;
        else m_psc = m_psc + 16'd1;
        if (wr) begin
            case (a)
                2'd0: m_en = PWDATA;
                2'd1: m_thresh = PWDATA[7:0];
                2'd2: m_pre = PWDATA[15:0];
                default: ;
            endcase
        end
        m_filt = nf;
        m_cnt  = nc;
        m_s    = m_s1;
        m_s1   = pad_in;
    endtask

    // Checks settled outputs, advances the model, then crosses one rising edge.
    task automatic cycle();
        #1;
        if (chk_en) begin
            chk("filt", gpio_filt, m_filt);
            chk("prdata", PRDATA, m_read(PADDR[3:2]));
        end
        model_step();
        @(posedge HCLK);
        #1;
    endtask

    task automatic apb_write(input logic [1:0] a, input logic [31:0] d);
        PSEL = 1; PENABLE = 0; PWRITE = 1; PADDR = {8'h0, a, 2'b00}; PWDATA = d;
        cycle();
        PENABLE = 1;
        cycle();
        PSEL = 0; PENABLE = 0; PWRITE = 0;
    endtask

    task automatic apb_read(input logic [1:0] a, output logic [31:0] rd);
        PSEL = 1; PENABLE = 0; PWRITE = 0; PADDR = {8'h0, a, 2'b00};
        cycle();
        PENABLE = 1;
        #1;
        rd = PRDATA;
        cycle();
        PSEL = 0; PENABLE = 0;
    endtask

    task automatic peek(input string tag, input logic [1:0] a, input logic [31:0] exp);
        PADDR = {8'h0, a, 2'b00};
        #1;
        chk(tag, PRDATA, exp);
    endtask

    task automatic count_until(input int b, input logic v, input int limit, output int n);
        n = 0;
        while (n < limit) begin
            cycle();
            n++;
            if (gpio_filt[b] === v) break;
        end
    endtask

    initial begin
        int          n;
        logic [31:0] rd, d;
        HRESET = 1; PADDR = 0; PWDATA = 0; PWRITE = 0; PSEL = 0; PENABLE = 0; pad_in = 0;
        cycle();
        cycle();
        chk_en = 1;
        HRESET = 0;

        // reset values
        peek("rst_en", 2'd0, 32'h0);
        peek("rst_thresh", 2'd1, 32'h10);
        peek("rst_presc", 2'd2, 32'h0);
        peek("rst_changed", 2'd3, 32'h0);
        chk("rst_filt", gpio_filt, 32'h0);
        chk("pready", {31'd0, PREADY}, 32'h1);
        chk("pslverr", {31'd0, PSLVERR}, 32'h0);

        // bypass latency
        pad_in[0] = 1;
        count_until(0, 1'b1, 10, n);
        chk("byp_latency", n, 3);
        peek("byp_changed", 2'd3, 32'h1);

        // filter, THRESH=4
        apb_write(2'd0, 32'h1);
        apb_write(2'd1, 32'd4);
        pad_in[0] = 0;
        count_until(0, 1'b0, 20, n);
        chk("flt_fall_latency", n, 6);
        pad_in[0] = 1;
        repeat (3) cycle();
        pad_in[0] = 0;
        repeat (10) cycle();
        chk("flt_glitch_rejected", {31'd0, gpio_filt[0]}, 32'h0);
        pad_in[0] = 1;
        count_until(0, 1'b1, 20, n);
        chk("flt_rise_latency", n, 6);

        // THRESH=0 behaves as THRESH=1
        apb_write(2'd1, 32'd0);
        pad_in[0] = 0;
        count_until(0, 1'b0, 20, n);
        chk("thr0_latency", n, 3);
        apb_write(2'd1, 32'd1);
        pad_in[0] = 1;
        count_until(0, 1'b1, 20, n);
        chk("thr1_latency", n, 3);

        // prescaled ticks: THRESH=2, PRESCALE=9, tick every 10 cycles
        apb_write(2'd1, 32'd2);
        apb_write(2'd2, 32'd9);
        pad_in[0] = 0;
        repeat (15) cycle();
        pad_in[0] = 1;
        repeat (30) cycle();
        chk("psc_glitch_rejected", {31'd0, gpio_filt[0]}, 32'h1);
        pad_in[0] = 0;
        count_until(0, 1'b0, 40, n);
        chk("psc_latency", n, 15);

        // CHANGED read racing a pin change
        apb_write(2'd2, 32'd0);
        apb_write(2'd0, 32'd0);
        repeat (5) cycle();
        apb_read(2'd3, rd);
        peek("race_pre_clear", 2'd3, 32'h0);
        pad_in[5] = 1;
        cycle();
        apb_read(2'd3, rd);
        chk("race_read_old", rd, 32'h0);
        peek("race_after", 2'd3, 32'h20);

        // lowering THRESH below an advanced count releases on the next tick
        apb_write(2'd0, 32'h1);
        apb_write(2'd1, 32'd255);
        pad_in[0] = 1;
        repeat (101) cycle();
        chk("thr255_hold", {31'd0, gpio_filt[0]}, 32'h0);
        apb_write(2'd1, 32'd50);
        chk("thr50_not_yet", {31'd0, gpio_filt[0]}, 32'h0);
        cycle();
        chk("thr50_release", {31'd0, gpio_filt[0]}, 32'h1);

        // randomized traffic, model checked every cycle
        for (int it = 0; it < 500; it++) begin
            case ($urandom_range(0, 39))
                0: apb_write(2'd0, $urandom);
                1: begin
                    d = ($urandom & 32'hffff_ff00) | $urandom_range(0, 4);
                    apb_write(2'd1, d);
                end
                2: begin
                    d = ($urandom & 32'hffff_0000) | $urandom_range(0, 2);
                    apb_write(2'd2, d);
                end
                3: apb_write(2'd3, $urandom);
                4: apb_read(2'd3, rd);
                default: begin
                    pad_in = pad_in ^ ($urandom & $urandom & $urandom & $urandom);
                    PADDR = {8'h0, 2'($urandom_range(0, 3)), 2'b00};
                    cycle();
                end
            endcase
        end

        // reset while pin 3 is mid-count
        apb_write(2'd2, 32'd0);
        apb_write(2'd1, 32'd10);
        apb_write(2'd0, 32'h8);
        pad_in = 0;
        repeat (20) cycle();
        apb_read(2'd3, rd);
        pad_in[3] = 1;
        repeat (5) cycle();
        HRESET = 1;
        pad_in = 0;
        cycle();
        HRESET = 0;
        repeat (8) cycle();
        chk("rst_mid_filt", gpio_filt, 32'h0);
        peek("rst_mid_changed", 2'd3, 32'h0);
        peek("rst_mid_en", 2'd0, 32'h0);
        peek("rst_mid_thresh", 2'd1, 32'h10);
        peek("rst_mid_presc", 2'd2, 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
